// File: rtl/leitor_matricula.sv
// leitor_matricula: plate-capture and barrier sequencer.
//   Collects six 4-bit plate characters (one per Dig_Valid strobe), latches the
//   day code with the first character, presents A..F/Dia to the opening block
//   for one settling cycle (Matr_Pronta), then samples Barreira/MatrVal and
//   either drives Abrir for OPEN_CYCLES cycles or pulses Rejeitada/Invalida.
//   An inter-digit gap of TIMEOUT_CYCLES idle cycles aborts capture with Erro.
// Ports:
//   Clk, Reset_n (sync, active-low)  Dig_In[3:0], Dig_Valid, Dia_In[2:0]
//   A..F[3:0], Dia[2:0], Matr_Pronta  Barreira, MatrVal
//   Abrir, Ocupado, Rejeitada, Invalida, Erro (all registered)
module leitor_matricula #(
  parameter int unsigned OPEN_CYCLES    = 50,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Dig_In,
  input  logic       Dig_Valid,
  input  logic [2:0] Dia_In,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [3:0] F,
  output logic [2:0] Dia,
  output logic       Matr_Pronta,
  input  logic       Barreira,
  input  logic       MatrVal,
  output logic       Abrir,
  output logic       Ocupado,
  output logic       Rejeitada,
  output logic       Invalida,
  output logic       Erro
);

  localparam int unsigned TMAX = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_OPEN,
    S_REJECT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      dig_q [6];
  logic [3:0]      dig_d [6];
  logic [2:0]      dia_q, dia_d;
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            erro_d, inval_d;
  logic            matr_q, abrir_q, ocupado_q, rej_q, inval_q, erro_q;

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    dia_d   = dia_q;
    count_d = count_q;
    timer_d = timer_q;
    erro_d  = 1'b0;
    inval_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Dig_Valid) begin
          dig_d[0] = Dig_In;
          dia_d    = Dia_In;
          count_d  = 3'd1;
          timer_d  = '0;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // A strobe always wins over the timeout, even on the expiry cycle.
        if (Dig_Valid) begin
          dig_d[count_q] = Dig_In;
          count_d        = count_q + 3'd1;
          timer_d        = '0;
          if (count_q == 3'd5) state_d = S_CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          erro_d = 1'b1;
          for (int unsigned i = 0; i < 6; i++) dig_d[i] = '0;
          dia_d   = '0;
          count_d = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (Barreira) begin
          timer_d = '0;
          state_d = S_OPEN;
        end else begin
          inval_d = ~MatrVal;
          state_d = S_REJECT;
        end
      end
      S_OPEN: begin
        if (timer_q == TW'(OPEN_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output flags are registered from the next state so they align with it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      for (int unsigned i = 0; i < 6; i++) dig_q[i] <= '0;
      dia_q     <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      matr_q    <= 1'b0;
      abrir_q   <= 1'b0;
      ocupado_q <= 1'b0;
      rej_q     <= 1'b0;
      inval_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      dia_q     <= dia_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      matr_q    <= (state_d == S_CHECK);
      abrir_q   <= (state_d == S_OPEN);
      ocupado_q <= (state_d != S_IDLE);
      rej_q     <= (state_d == S_REJECT);
      inval_q   <= inval_d;
      erro_q    <= erro_d;
    end
  end

  assign A           = dig_q[0];
  assign B           = dig_q[1];
  assign C           = dig_q[2];
  assign D           = dig_q[3];
  assign E           = dig_q[4];
  assign F           = dig_q[5];
  assign Dia         = dia_q;
  assign Matr_Pronta = matr_q;
  assign Abrir       = abrir_q;
  assign Ocupado     = ocupado_q;
  assign Rejeitada   = rej_q;
  assign Invalida    = inval_q;
  assign Erro        = erro_q;

endmodule

// File: tb/tb_leitor_matricula.sv
// Testbench for leitor_matricula: directed scenarios followed by random plates,
// checked against expectations derived from the plate/verdict rules.
module tb_leitor_matricula;

  localparam int unsigned OPEN_N = 50;
  localparam int unsigned TMO_N  = 200;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Dig_In;
  logic       Dig_Valid;
  logic [2:0] Dia_In;
  logic [3:0] A, B, C, D, E, F;
  logic [2:0] Dia;
  logic       Matr_Pronta, Barreira, MatrVal;
  logic       Abrir, Ocupado, Rejeitada, Invalida, Erro;

  int n_tests = 0;
  int n_fail  = 0;

  leitor_matricula #(.OPEN_CYCLES(OPEN_N), .TIMEOUT_CYCLES(TMO_N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Dig_In(Dig_In), .Dig_Valid(Dig_Valid), .Dia_In(Dia_In),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .Dia(Dia), .Matr_Pronta(Matr_Pronta),
    .Barreira(Barreira), .MatrVal(MatrVal), .Abrir(Abrir), .Ocupado(Ocupado),
    .Rejeitada(Rejeitada), .Invalida(Invalida), .Erro(Erro)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  function automatic logic [23:0] pack(input logic [3:0] d [6]);
    return {d[0], d[1], d[2], d[3], d[4], d[5]};
  endfunction

  function automatic logic [23:0] plate_out();
    return {A, B, C, D, E, F};
  endfunction

  task automatic strobe(input logic [3:0] d, input logic [2:0] dia);
    Dig_In = d; Dia_In = dia; Dig_Valid = 1'b1;
    step();
    Dig_Valid = 1'b0;
  endtask

  // Sends six characters with random idle gaps; ends in the CHECK cycle.
  task automatic send_plate(input logic [3:0] d [6], input logic [2:0] dia,
                            input logic bar, input logic mv, input int unsigned maxgap);
    Barreira = bar; MatrVal = mv;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) repeat ($urandom_range(maxgap, 0)) step();
      // Dia_In only matters with the first character; noise on the rest.
      strobe(d[i], (i == 0) ? dia : 3'($urandom));
      if (i == 0) chk("ocupado_capture", Ocupado, 1);
    end
    chk("matr_pronta_check", Matr_Pronta, 1);
    chk("plate_check", plate_out(), pack(d));
    chk("dia_check", Dia, dia);
  endtask

  // Follows the verdict; optionally strobes 0xD mid-OPEN (must be ignored).
  task automatic verdict(input logic [3:0] d [6], input logic [2:0] dia,
                         input logic bar, input logic mv, input logic busy_strobe);
    int cnt;
    step();
    chk("matr_pronta_1cyc", Matr_Pronta, 0);
    if (bar) begin
      cnt = 0;
      while (Abrir === 1'b1 && cnt < int'(OPEN_N) + 20) begin
        cnt++;
        if (busy_strobe && cnt == 5) begin
          Dig_In = 4'hD; Dia_In = 3'd0; Dig_Valid = 1'b1;
        end else begin
          Dig_Valid = 1'b0;
        end
        step();
      end
      Dig_Valid = 1'b0;
      chk("abrir_cycles", cnt, OPEN_N);
      chk("ocupado_after_open", Ocupado, 0);
    end else begin
      chk("rejeitada_pulse", Rejeitada, 1);
      chk("invalida_pulse", Invalida, !mv);
      chk("abrir_reject", Abrir, 0);
      step();
      chk("rejeitada_end", Rejeitada, 0);
      chk("invalida_end", Invalida, 0);
      chk("ocupado_after_rej", Ocupado, 0);
    end
    chk("plate_held", plate_out(), pack(d));
    chk("dia_held", Dia, dia);
  endtask

  initial begin
    logic [3:0] p [6];
    logic [2:0] dia;
    logic       bar, mv, erro_seen;

    Reset_n = 1'b0; Dig_In = '0; Dig_Valid = 1'b0; Dia_In = '0; Barreira = 1'b0; MatrVal = 1'b0;

    // Reset
    step(); step();
    chk("rst_plate", plate_out(), 0);
    chk("rst_dia", Dia, 0);
    chk("rst_flags", {Abrir, Ocupado, Erro, Rejeitada, Invalida, Matr_Pronta}, 0);
    Reset_n = 1'b1;
    step();

    // Accept, with an ignored strobe during OPEN
    p = '{4'h3, 4'h4, 4'hA, 4'h3, 4'h6, 4'h6};
    send_plate(p, 3'd1, 1'b1, 1'b1, 0);
    verdict(p, 3'd1, 1'b1, 1'b1, 1'b1);

    // Capture after OPEN must start clean
    p = '{4'hB, 4'hD, 4'h9, 4'h7, 4'h5, 4'h2};
    send_plate(p, 3'd5, 1'b0, 1'b1, 2);
    verdict(p, 3'd5, 1'b0, 1'b1, 1'b0);

    // Reject invalid
    p = '{4'hB, 4'hB, 4'hA, 4'hB, 4'hF, 4'hF};
    send_plate(p, 3'd7, 1'b0, 1'b0, 0);
    verdict(p, 3'd7, 1'b0, 1'b0, 1'b0);

    // Timeout: 200 idle cycles after the third character
    strobe(4'h1, 3'd3); strobe(4'h2, 3'd0); strobe(4'h3, 3'd0);
    erro_seen = 1'b0;
    for (int i = 1; i < int'(TMO_N); i++) begin
      step();
      if (Erro === 1'b1) erro_seen = 1'b1;
    end
    chk("erro_early", erro_seen, 0);
    step();
    chk("erro_pulse", Erro, 1);
    chk("timeout_plate", plate_out(), 0);
    chk("timeout_dia", Dia, 0);
    chk("timeout_ocupado", Ocupado, 0);
    step();
    chk("erro_end", Erro, 0);

    // Strobe exactly on the expiry cycle is taken
    Barreira = 1'b0; MatrVal = 1'b1;
    strobe(4'h1, 3'd2); strobe(4'h2, 3'd0); strobe(4'h3, 3'd0);
    repeat (TMO_N - 1) step();
    strobe(4'h4, 3'd0);
    chk("expiry_no_erro", Erro, 0);
    chk("expiry_ocupado", Ocupado, 1);
    strobe(4'h5, 3'd0);
    strobe(4'h6, 3'd0);
    p = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    chk("expiry_matr", Matr_Pronta, 1);
    chk("expiry_plate", plate_out(), pack(p));
    verdict(p, 3'd2, 1'b0, 1'b1, 1'b0);

    // Random plates
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 6; i++) p[i] = 4'($urandom);
      dia = 3'($urandom);
      bar = 1'($urandom);
      mv  = 1'($urandom);
      send_plate(p, dia, bar, mv, 5);
      verdict(p, dia, bar, mv, 1'($urandom));
    end

    // Reset in the middle of OPEN
    p = '{4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    send_plate(p, 3'd4, 1'b1, 1'b1, 1);
    repeat (10) step();
    chk("mid_open_abrir", Abrir, 1);
    Reset_n = 1'b0;
    step();
    chk("midrst_abrir", Abrir, 0);
    chk("midrst_plate", plate_out(), 0);
    chk("midrst_dia", Dia, 0);
    chk("midrst_ocupado", Ocupado, 0);
    Reset_n = 1'b1;
    step();
    p = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    send_plate(p, 3'd6, 1'b1, 1'b0, 1);
    verdict(p, 3'd6, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
